intr_ctrl: RTL and testbench

//  Parametrised interrupt controller between external/timer interrupt sources and the core's CSR/trap logic.

---
 rtl/intr_pkg.sv | 28 ++
 rtl/intr_timer.sv | 44 ++++
 rtl/intr_ctrl.sv | 173 +++++++++++++++++
 tb/tb_intr_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt controller.
//   intr_state_e : handshake state (IDLE -> REQ -> SERVICE -> IDLE)
//   CAUSE_NONE   : cause value reported when no request is active
//   prio_enc()   : lowest set index + 1 of a source vector, 0 when empty
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_e;

    localparam int         MAX_SRC    = 16;
    localparam logic [7:0] CAUSE_NONE = 8'd0;

    // Scans from the top so the lowest set index is the last one written.
    function automatic logic [7:0] prio_enc(input logic [MAX_SRC-1:0] vec);
        logic [7:0] cause;
        cause = CAUSE_NONE;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                cause = 8'(i + 1);
            end
        end
        return cause;
    endfunction

endpackage

// File: rtl/intr_timer.sv
// Free-running overflow timer feeding interrupt source 0.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_en          : count enable
//   i_reload      : value loaded when the counter wraps from all-ones
//   o_ovf         : 1-cycle pulse, high in the cycle whose clock edge wraps
module intr_timer
    import intr_pkg::*;
#(
    parameter int TMR_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [TMR_W-1:0] i_reload,
    output logic             o_ovf
);

    localparam logic [TMR_W-1:0] CNT_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    logic [TMR_W-1:0] r_cnt;
    logic             w_wrap;

    // The pulse coincides with the reload edge so the pending bit sets on the wrap itself.
    always_comb begin
        w_wrap = i_en & (&r_cnt);
    end

    // Counter: reload on wrap, otherwise count while enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= i_reload;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_ovf = w_wrap;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller between interrupt sources and the core trap logic.
// Latches pending bits (edge or level per source), masks them with the
// per-source enable and global enable, picks the lowest eligible index and
// runs a one-at-a-time req -> ack -> done handshake with the core.
// Build option: define INTR_TIMER_EN to attach an internal overflow timer to
// source 0 (src_irq[0] is then ignored); otherwise tmr_en/tmr_reload are unused.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_src_irq      : raw source lines (synchronous to i_clk)
//   i_src_edge     : per-source mode, 1 = rising edge, 0 = level
//   i_src_en       : per-source enable
//   i_global_ie    : global interrupt enable
//   i_irq_ack      : pulse, core took the trap for o_irq_cause
//   i_irq_done     : pulse, core executed mret
//   o_irq_req      : interrupt request
//   o_irq_cause    : winning index + 1, 0 when no request
//   o_pending      : pending register image
//   i_tmr_en       : timer count enable
//   i_tmr_reload   : timer reload value
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 4,
    parameter int TMR_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_SRC-1:0]   i_src_irq,
    input  logic [N_SRC-1:0]   i_src_edge,
    input  logic [N_SRC-1:0]   i_src_en,
    input  logic               i_global_ie,
    input  logic               i_irq_ack,
    input  logic               i_irq_done,
    output logic               o_irq_req,
    output logic [CAUSE_W-1:0] o_irq_cause,
    output logic [N_SRC-1:0]   o_pending,
    input  logic               i_tmr_en,
    input  logic [TMR_W-1:0]   i_tmr_reload
);

    localparam logic [N_SRC-1:0] SRC_ONE = {{(N_SRC-1){1'b0}}, 1'b1};

    intr_state_e        r_state;
    intr_state_e        w_state_next;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_src_prev;
    logic [N_SRC-1:0]   r_sel;          // one-hot captured source
    logic [N_SRC-1:0]   w_sel_next;
    logic               r_irq_req;
    logic [CAUSE_W-1:0] r_irq_cause;
    logic [N_SRC-1:0]   w_edge_mode;
    logic [N_SRC-1:0]   w_set;
    logic [N_SRC-1:0]   w_elig;
    logic [N_SRC-1:0]   w_ack_clr;
    logic [N_SRC-1:0]   w_pend_next;

`ifdef INTR_TIMER_EN
    logic w_tmr_ovf;
    logic w_unused_src0;

    intr_timer #(.TMR_W(TMR_W)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_tmr_en),
        .i_reload (i_tmr_reload),
        .o_ovf    (w_tmr_ovf)
    );

    assign w_unused_src0 = i_src_irq[0] ^ r_src_prev[0];

    // Source 0 belongs to the timer: always edge-type, set only by overflow.
    always_comb begin
        w_edge_mode = {i_src_edge[N_SRC-1:1], 1'b1};
        w_set       = {i_src_irq[N_SRC-1:1] & ~r_src_prev[N_SRC-1:1], w_tmr_ovf};
    end
`else
    logic w_unused_tmr;

    assign w_unused_tmr = ^{i_tmr_en, i_tmr_reload};

    // All sources are external.
    always_comb begin
        w_edge_mode = i_src_edge;
        w_set       = i_src_irq & ~r_src_prev;
    end
`endif

    // Pending update: level sources mirror the line, edge sources latch rising
    // edges and clear on ack of the captured source; a same-cycle set wins.
    always_comb begin
        w_elig      = r_pending & i_src_en & {N_SRC{i_global_ie}};
        w_ack_clr   = '0;
        w_pend_next = r_pending;
        if ((r_state == REQ) && i_irq_ack) begin
            w_ack_clr = r_sel & w_edge_mode;
        end else begin
            w_ack_clr = '0;
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (w_edge_mode[i]) begin
                w_pend_next[i] = w_set[i] | (r_pending[i] & ~w_ack_clr[i]);
            end else begin
                w_pend_next[i] = i_src_irq[i];
            end
        end
    end

    // Handshake next-state; the winner is captured once and held through REQ.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        case (r_state)
            IDLE: begin
                if (|w_elig) begin
                    w_state_next = REQ;
                    w_sel_next   = w_elig & (~w_elig + SRC_ONE);  // isolate lowest set bit
                end else begin
                    w_state_next = IDLE;
                end
            end
            REQ: begin
                if (i_irq_ack) begin
                    w_state_next = SERVICE;
                end else if (~|(w_elig & r_sel)) begin
                    w_state_next = IDLE;  // captured source withdrawn before ack
                end else begin
                    w_state_next = REQ;
                end
            end
            SERVICE: begin
                if (i_irq_done) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = SERVICE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_sel_next   = '0;
            end
        endcase
    end

    // State, pending and registered request outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_pending   <= '0;
            r_src_prev  <= '0;
            r_irq_req   <= 1'b0;
            r_irq_cause <= CAUSE_W'(CAUSE_NONE);
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_pending  <= w_pend_next;
            r_src_prev <= i_src_irq;
            if (w_state_next == REQ) begin
                r_irq_req   <= 1'b1;
                r_irq_cause <= CAUSE_W'(prio_enc(MAX_SRC'(w_sel_next)));
            end else begin
                r_irq_req   <= 1'b0;
                r_irq_cause <= CAUSE_W'(CAUSE_NONE);
            end
        end
    end

    assign o_irq_req   = r_irq_req;
    assign o_irq_cause = r_irq_cause;
    assign o_pending   = r_pending;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl (N_SRC=4, CAUSE_W=4, TMR_W=4).
module tb_intr_ctrl;

`ifdef INTR_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic       clk;
    logic       i_rst;
    logic [3:0] i_src_irq, i_src_edge, i_src_en;
    logic       i_global_ie, i_irq_ack, i_irq_done;
    logic       o_irq_req;
    logic [3:0] o_irq_cause;
    logic [3:0] o_pending;
    logic       i_tmr_en;
    logic [3:0] i_tmr_reload;

    int n_checks = 0;
    int n_errors = 0;

    intr_ctrl #(.N_SRC(4), .CAUSE_W(4), .TMR_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_src_irq    (i_src_irq),
        .i_src_edge   (i_src_edge),
        .i_src_en     (i_src_en),
        .i_global_ie  (i_global_ie),
        .i_irq_ack    (i_irq_ack),
        .i_irq_done   (i_irq_done),
        .o_irq_req    (o_irq_req),
        .o_irq_cause  (o_irq_cause),
        .o_pending    (o_pending),
        .i_tmr_en     (i_tmr_en),
        .i_tmr_reload (i_tmr_reload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic       ack;
        logic       done;
        logic       exp_req;
        logic [3:0] exp_cause;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t tbl[$];

    // reference model state: phase 0=idle 1=requesting 2=in service
    logic [3:0] m_pend, m_prev;
    int         m_phase, m_sel, m_cause;
    logic       m_req;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic req, input logic [3:0] cause,
                           input logic [3:0] pend);
        chk(name, {23'd0, o_irq_req, o_irq_cause, o_pending}, {23'd0, req, cause, pend});
    endtask

    task automatic add(input logic [3:0] irq, input logic ack, input logic done,
                       input logic req, input logic [3:0] cause, input logic [3:0] pend);
        vec_t v;
        v.irq = irq; v.ack = ack; v.done = done;
        v.exp_req = req; v.exp_cause = cause; v.exp_pend = pend;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        i_src_irq = 4'd0; i_irq_ack = 1'b0; i_irq_done = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    // One clock of the spec's rules, evaluated on the inputs about to be sampled.
    task automatic model_clock();
        logic [3:0] elig, np, emode;
        logic       rise, clr;
        int         nphase, nsel;
        if (i_rst) begin
            m_pend = 4'd0; m_prev = 4'd0; m_phase = 0; m_sel = 0;
            m_req = 1'b0; m_cause = 0;
            return;
        end
        emode = i_src_edge;
        if (TIMER) emode[0] = 1'b1;
        elig = m_pend & i_src_en & {4{i_global_ie}};
        for (int i = 0; i < 4; i++) begin
            if (emode[i]) begin
                rise = i_src_irq[i] && !m_prev[i];
                if (TIMER && i == 0) rise = 1'b0;  // timer is frozen during random phase
                clr = (m_phase == 1) && i_irq_ack && (m_sel == i);
                np[i] = rise || (m_pend[i] && !clr);
            end else begin
                np[i] = i_src_irq[i];
            end
        end
        nphase = m_phase;
        nsel   = m_sel;
        if (m_phase == 0) begin
            if (elig != 4'd0) begin
                nphase = 1;
                for (int i = 3; i >= 0; i--) if (elig[i]) nsel = i;
            end
        end else if (m_phase == 1) begin
            if (i_irq_ack) nphase = 2;
            else if (!elig[m_sel]) nphase = 0;
        end else begin
            if (i_irq_done) nphase = 0;
        end
        m_pend  = np;
        m_prev  = i_src_irq;
        m_phase = nphase;
        m_sel   = nsel;
        m_req   = (nphase == 1);
        m_cause = m_req ? nsel + 1 : 0;
    endtask

    initial begin
        i_rst = 1'b1; i_src_irq = 4'd0; i_src_edge = 4'hF; i_src_en = 4'hF;
        i_global_ie = 1'b1; i_irq_ack = 1'b0; i_irq_done = 1'b0;
        i_tmr_en = 1'b0; i_tmr_reload = 4'hC;

        // reset state
        do_reset();
        chk("reset_req", {31'd0, o_irq_req}, 32'd0);
        chk("reset_cause", {28'd0, o_irq_cause}, 32'd0);
        chk("reset_pend", {28'd0, o_pending}, 32'd0);

        // table: all edge, all enabled, global_ie=1
        add(4'b0100, 0, 0, 0, 4'd0, 4'b0100);  // edge latched
        add(4'b0000, 0, 0, 1, 4'd3, 4'b0100);  // request one cycle later
        add(4'b0000, 0, 0, 1, 4'd3, 4'b0100);
        add(4'b0000, 1, 0, 0, 4'd0, 4'b0000);  // ack clears edge pending
        add(4'b0000, 0, 1, 0, 4'd0, 4'b0000);  // done
        add(4'b0000, 0, 0, 0, 4'd0, 4'b0000);
        add(4'b1010, 0, 0, 0, 4'd0, 4'b1010);  // two sources together
        add(4'b1010, 0, 0, 1, 4'd2, 4'b1010);  // lower index wins
        add(4'b0000, 1, 0, 0, 4'd0, 4'b1000);
        add(4'b0000, 0, 1, 0, 4'd0, 4'b1000);  // pending[3] held
        add(4'b0000, 0, 0, 1, 4'd4, 4'b1000);
        add(4'b0000, 1, 0, 0, 4'd0, 4'b0000);
        add(4'b0000, 0, 1, 0, 4'd0, 4'b0000);
        add(4'b0100, 0, 0, 0, 4'd0, 4'b0100);  // re-set together with ack
        add(4'b0000, 0, 0, 1, 4'd3, 4'b0100);
        add(4'b0100, 1, 0, 0, 4'd0, 4'b0100);  // set wins over ack clear
        add(4'b0000, 0, 1, 0, 4'd0, 4'b0100);
        add(4'b0000, 0, 0, 1, 4'd3, 4'b0100);  // second request
        add(4'b0000, 1, 0, 0, 4'd0, 4'b0000);
        add(4'b0000, 0, 1, 0, 4'd0, 4'b0000);
        add(4'b0000, 1, 0, 0, 4'd0, 4'b0000);  // stray ack in IDLE
        add(4'b1000, 0, 0, 0, 4'd0, 4'b1000);
        add(4'b0010, 0, 0, 1, 4'd4, 4'b1010);  // higher priority arrives
        add(4'b0000, 0, 0, 1, 4'd4, 4'b1010);  // cause held
        add(4'b0000, 1, 0, 0, 4'd0, 4'b0010);
        add(4'b0000, 0, 1, 0, 4'd0, 4'b0010);
        add(4'b0000, 0, 0, 1, 4'd2, 4'b0010);
        add(4'b0000, 1, 0, 0, 4'd0, 4'b0000);
        add(4'b0000, 0, 1, 0, 4'd0, 4'b0000);
        for (int k = 0; k < tbl.size(); k++) begin
            i_src_irq = tbl[k].irq; i_irq_ack = tbl[k].ack; i_irq_done = tbl[k].done;
            step();
            chk_out($sformatf("tbl%0d", k), tbl[k].exp_req, tbl[k].exp_cause, tbl[k].exp_pend);
        end
        idle_inputs();

        // level source 1 masked by global_ie, then withdrawn before ack
        i_src_edge = 4'b1101; i_global_ie = 1'b0; i_src_irq = 4'b0010;
        step(); chk_out("lvl_masked0", 1'b0, 4'd0, 4'b0010);
        step(); chk_out("lvl_masked1", 1'b0, 4'd0, 4'b0010);
        i_global_ie = 1'b1;
        step(); chk_out("lvl_req", 1'b1, 4'd2, 4'b0010);
        i_src_irq = 4'b0000;
        step(); chk_out("lvl_drop0", 1'b1, 4'd2, 4'b0000);
        step(); chk_out("lvl_drop1", 1'b0, 4'd0, 4'b0000);
        step(); chk_out("lvl_idle", 1'b0, 4'd0, 4'b0000);

        // reset while in SERVICE, then stray done
        i_src_edge = 4'hF; i_src_irq = 4'b1010;
        step(); step();
        chk_out("svc_req", 1'b1, 4'd2, 4'b1010);
        i_irq_ack = 1'b1;
        step(); i_irq_ack = 1'b0; i_src_irq = 4'b0000;
        step(); i_src_irq = 4'b0010;
        step(); chk_out("svc_pend", 1'b0, 4'd0, 4'b1010);
        i_src_irq = 4'b0000; i_rst = 1'b1;
        step(); chk_out("svc_rst", 1'b0, 4'd0, 4'b0000);
        i_rst = 1'b0; i_irq_done = 1'b1;
        step(); chk_out("stray_done", 1'b0, 4'd0, 4'b0000);
        i_irq_done = 1'b0;
        step(); chk_out("post_rst", 1'b0, 4'd0, 4'b0000);

`ifdef INTR_TIMER_EN
        // timer: 16 counts to first wrap, then every 4 from reload C
        i_tmr_en = 1'b1; i_tmr_reload = 4'hC;
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            i_src_irq = (k == 3) ? 4'b0001 : 4'b0000;  // raw line 0 must be ignored
            step(); chk_out($sformatf("tmr_cnt%0d", k), 1'b0, 4'd0, 4'b0000);
        end
        i_src_irq = 4'b0000;
        step(); chk_out("tmr_ovf1", 1'b0, 4'd0, 4'b0001);
        step(); chk_out("tmr_req1", 1'b1, 4'd1, 4'b0001);
        i_irq_ack = 1'b1;
        step(); chk_out("tmr_ack", 1'b0, 4'd0, 4'b0000);
        i_irq_ack = 1'b0; i_irq_done = 1'b1;
        step(); chk_out("tmr_done", 1'b0, 4'd0, 4'b0000);
        i_irq_done = 1'b0; i_src_irq = 4'b0010;
        step(); chk_out("tmr_ovf2", 1'b0, 4'd0, 4'b0011);
        i_src_irq = 4'b0000;
        step(); chk_out("tmr_wins", 1'b1, 4'd1, 4'b0011);
        i_tmr_en = 1'b0;
`endif

        // randomized run against the reference model
        i_tmr_en = 1'b0;
        do_reset();
        model_clock();
        i_rst = 1'b1; model_clock(); i_rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c % 64 == 0) i_src_edge = 4'($urandom);
            if ($urandom_range(0, 15) == 0) i_src_en = 4'($urandom);
            i_global_ie = ($urandom_range(0, 7) != 0);
            i_src_irq   = i_src_irq ^ (4'($urandom) & 4'($urandom));
            i_irq_ack   = ((m_phase == 1) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 24) == 0);
            i_irq_done  = ((m_phase == 2) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 24) == 0);
            i_rst       = ($urandom_range(0, 99) == 0);
            model_clock();
            step();
            chk_out($sformatf("rand%0d", c), m_req, 4'(m_cause), m_pend);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
